ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative signed 16x16 multiply / 16/16 divide unit in the EXECUTE stage, fed from the ID/EX buffer.
//  Multiply returns a 32-bit product. Divide returns quotient and remainder.
//  The high word / remainder is the value written to R0 through the register file's write_r0 path.
//  While an operation runs, it holds the front of the pipeline through the hazard unit via stall.
// PARAMETERS
//  WIDTH  16  operand width; iteration count = WIDTH
// PORTS
//  clock         in   1      rising-edge clock
//  reset         in   1      synchronous, active-low reset
//  start         in   1      request op; level, sampled only in IDLE
//  op            in   1      0 = signed multiply, 1 = signed divide
//  operand_a     in   WIDTH  multiplicand / dividend (op1 register data)
//  operand_b     in   WIDTH  multiplier / divisor (op2 register data)
//  flush         in   1      abort from branch control; synchronous
//  stall         out  1      hold PC, IF/ID and ID/EX
//  busy          out  1      high in RUN
//  done          out  1      one-cycle pulse; results valid
//  result_lo     out  WIDTH  product[15:0] / quotient
//  result_hi     out  WIDTH  product[31:16] / remainder (to R0)
//  div_by_zero   out  1      valid with done; divide with operand_b == 0
// BEHAVIOUR
//  Reset (reset==0 at edge):
//   - state=IDLE; busy, done, div_by_zero, result_lo and result_hi all cleared to 0.
//   - Reset wins over every other input, including mid-RUN.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE, start=1, flush=0: latch |a|, |b|, operand signs and op; clear the iteration count.
//     - If op=1 and b==0: go to DONE with result_lo=16'hFFFF, result_hi=operand_a, div_by_zero=1.
//     - Otherwise go to RUN.
//   - RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle.
//     - Exactly WIDTH steps; the edge performing step WIDTH moves to DONE.
//     - Sign correction is applied to the registered results on that same edge.
//   - DONE: done=1 for exactly one cycle, then IDLE. start is not sampled in DONE.
//  Latency: start accepted at edge E0.
//   - done is high in the cycle after edge E0+WIDTH (16 cycles).
//   - Divide-by-zero: done is high in the cycle after edge E0.
//  stall = (state==IDLE & start & ~flush) | (state==RUN); low in DONE.
//   - The EX/MEM buffer therefore captures the results at the edge ending the DONE cycle.
//  Arithmetic: two's complement.
//   - Product is the full 32-bit signed value.
//   - Quotient truncates toward zero; remainder takes the sign of the dividend.
//   - 16'h8000 / 16'hFFFF gives quotient 16'h8000, remainder 0 (wrap, no flag).
//  result_lo / result_hi / div_by_zero are updated only on entry to DONE.
//   - They hold their values until the next completed operation; they are not cleared by flush.
//  flush=1 at an edge:
//   - Any state goes to IDLE; busy=0 and done=0.
//   - The in-flight operation is discarded.
//   - flush has priority over start in the same cycle.
//  Operand inputs are ignored after the accepting edge; changes during RUN do not affect the result.
// TESTING
//  1) mul 16'h0007 * 16'hFFFD:
//     - done exactly 16 cycles after accept; stall high 17 consecutive cycles.
//     - Result: hi=16'hFFFF, lo=16'hFFEB.
//  2) mul 16'h7FFF * 16'h7FFF -> hi=16'h3FFF, lo=16'h0001; mul 16'h8000 * 16'h8000 -> hi=16'h4000, lo=16'h0000.
//  3) div 16'hFFF9 / 16'h0002 (-7/2) -> lo=16'hFFFD, hi=16'hFFFF. div 16'h8000 / 16'hFFFF -> lo=16'h8000, hi=16'h0000.
//  4) div 16'h0005 / 16'h0000:
//     - done and div_by_zero high in the cycle after the accepting edge.
//     - lo=16'hFFFF, hi=16'h0005; stall high for 1 cycle only.
//  5) mul 3*4 with flush at RUN step 5:
//     - Next cycle IDLE; stall, busy and done are 0; outputs keep the prior values.
//     - A new start for 3*4 then yields lo=16'h000C, hi=16'h0000.
//  6) reset low during RUN step 8 -> all outputs 0 after that edge. start+flush in the same IDLE cycle -> not accepted, stall=0.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Request/result bundle between the ID/EX buffer, the hazard unit and the
// EX-stage multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, flush,
        input  stall, busy, done, result_lo, result_hi, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush,
        output stall, busy, done, result_lo, result_hi, div_by_zero
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative signed WIDTHxWIDTH multiply / WIDTH/WIDTH divide for the EXECUTE stage.
// Works on magnitudes, one shift-add or restoring shift-subtract step per cycle.
module ex_muldiv_unit #(
    parameter int WIDTH = 16
) (
    input logic                clock,
    input logic                reset,
    ex_muldiv_unit_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             op_q, op_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             b_is_zero;
    logic             last_step;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] mag_full;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             stall_o;
    logic             busy_o;
    logic             done_o;

    assign accept    = (state_q == S_IDLE) && bus.start && !bus.flush;
    assign b_is_zero = (bus.operand_b == '0);
    assign last_step = (count_q == CW'(WIDTH - 1));
    assign a_mag     = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
    assign b_mag     = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;

    // hi/lo hold partial product (mul) or partial remainder/quotient (div)
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (op_q) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        mag_full  = {step_hi, step_lo};
        product   = (neg_a_q ^ neg_b_q) ? -mag_full : mag_full;
        quotient  = (neg_a_q ^ neg_b_q) ? -step_lo : step_lo;
        remainder = neg_a_q ? -step_hi : step_hi;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (bus.op && b_is_zero) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        stall_o = accept || (state_q == S_RUN);
        busy_o  = (state_q == S_RUN);
        done_o  = (state_q == S_DONE);
    end

    // Results change only on entry to DONE; a flushed operation leaves them alone
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        count_d  = count_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
        if (accept) begin
            hi_d    = '0;
            lo_d    = a_mag;
            b_d     = b_mag;
            op_d    = bus.op;
            neg_a_d = bus.operand_a[WIDTH-1];
            neg_b_d = bus.operand_b[WIDTH-1];
            count_d = '0;
            if (bus.op && b_is_zero) begin
                res_lo_d = '1;
                res_hi_d = bus.operand_a;
                dbz_d    = 1'b1;
            end
        end else if (state_q == S_RUN && !bus.flush) begin
            hi_d    = step_hi;
            lo_d    = step_lo;
            count_d = count_q + 1'b1;
            if (last_step) begin
                dbz_d = 1'b0;
                if (op_q) begin
                    res_lo_d = quotient;
                    res_hi_d = remainder;
                end else begin
                    res_lo_d = product[WIDTH-1:0];
                    res_hi_d = product[2*WIDTH-1:WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            count_q  <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            count_q  <= count_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.stall       = stall_o;
    assign bus.busy        = busy_o;
    assign bus.done        = done_o;
    assign bus.result_lo   = res_lo_q;
    assign bus.result_hi   = res_hi_q;
    assign bus.div_by_zero = dbz_q;
endmodule
